obj_row_scanout: RTL and testbench

OBJ_ROW_SCANOUT -- requirements
Module: obj_row_scanout

---
 rtl/obj_pkg.sv | 14 +
 rtl/obj_row_scanout_if.sv | 44 ++++
 rtl/obj_mosaic_col.sv | 13 +
 rtl/obj_row_scanout.sv | 112 +++++++++++
 tb/tb_obj_row_scanout.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/obj_pkg.sv
// Shared OBJ types: visible column count, buffer pixel word, scanout FSM states.
package obj_pkg;
  localparam int OBJ_NCOLS = 240;

  typedef logic [19:0] obj_pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_CLEAR,
    ST_DONE
  } obj_scan_state_t;
endpackage

// File: rtl/obj_row_scanout_if.sv
// Bus between the OBJ row scanout, the OBJ row buffer and the compositor.
// Carries mosaic_h only when OBJ_SCANOUT_MOSAIC_EN is defined.
interface obj_row_scanout_if;
  import obj_pkg::*;

  logic       line_start;
  logic [7:0] row;
  logic [7:0] row_q;
  logic [7:0] rcol;
  obj_pixel_t rdata;
  logic       buf_clear;
  obj_pixel_t pix_data;
  logic [7:0] pix_col;
  logic       pix_valid;
  logic       pix_ready;
  logic       line_done;
  logic       busy;
  logic       overrun;
`ifdef OBJ_SCANOUT_MOSAIC_EN
  logic [3:0] mosaic_h;

  modport slave (
    input  line_start, row, rdata, pix_ready, mosaic_h,
    output row_q, rcol, buf_clear, pix_data, pix_col, pix_valid,
           line_done, busy, overrun
  );
  modport master (
    output line_start, row, rdata, pix_ready, mosaic_h,
    input  row_q, rcol, buf_clear, pix_data, pix_col, pix_valid,
           line_done, busy, overrun
  );
`else
  modport slave (
    input  line_start, row, rdata, pix_ready,
    output row_q, rcol, buf_clear, pix_data, pix_col, pix_valid,
           line_done, busy, overrun
  );
  modport master (
    output line_start, row, rdata, pix_ready,
    input  row_q, rcol, buf_clear, pix_data, pix_col, pix_valid,
           line_done, busy, overrun
  );
`endif
endinterface

// File: rtl/obj_mosaic_col.sv
// Maps an output column to the first column of its horizontal mosaic block.
module obj_mosaic_col (
  input  logic [7:0] col_i,
  input  logic [3:0] size_m1_i,
  output logic [7:0] base_o
);
  logic [7:0] blk;
  logic [7:0] rem;

  assign blk    = {4'd0, size_m1_i} + 8'd1;
  assign rem    = col_i % blk;
  assign base_o = col_i - rem;
endmodule

// File: rtl/obj_row_scanout.sv
// Streams one OBJ row buffer line to the compositor, then clears that buffer half.
// Optional horizontal mosaic addressing under OBJ_SCANOUT_MOSAIC_EN.
module obj_row_scanout
  import obj_pkg::*;
#(
  parameter int NCOLS    = OBJ_NCOLS,
  parameter int LAST_COL = NCOLS - 1
) (
  input  logic               clock,
  input  logic               reset,
  obj_row_scanout_if.slave   bus
);
  localparam logic [7:0] LAST_C = 8'(LAST_COL);

  obj_scan_state_t state_q, state_d;
  logic [7:0]      col_q, col_d;
  logic [7:0]      row_q, row_d;
  obj_pixel_t      pix_data_q, pix_data_d;
  logic [7:0]      pix_col_q, pix_col_d;
  logic            pix_valid_q, pix_valid_d;
  logic            overrun_q, overrun_d;
`ifdef OBJ_SCANOUT_MOSAIC_EN
  logic [3:0]      mos_q, mos_d;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pix_data_d  = pix_data_q;
    pix_col_d   = pix_col_q;
    pix_valid_d = pix_valid_q;
    overrun_d   = overrun_q;
`ifdef OBJ_SCANOUT_MOSAIC_EN
    mos_d       = mos_q;
`endif
    if (bus.line_start && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: if (bus.line_start) begin
        row_d   = bus.row;
        col_d   = 8'd0;
`ifdef OBJ_SCANOUT_MOSAIC_EN
        mos_d   = bus.mosaic_h;
`endif
        state_d = ST_SCAN;
      end
      // Output register refills when empty or when its pixel is taken this cycle.
      ST_SCAN: if (!pix_valid_q || bus.pix_ready) begin
        pix_data_d  = bus.rdata;
        pix_col_d   = col_q;
        pix_valid_d = 1'b1;
        if (col_q == LAST_C) state_d = ST_DRAIN;
        else                 col_d   = col_q + 8'd1;
      end
      ST_DRAIN: if (bus.pix_ready) begin
        pix_valid_d = 1'b0;
        state_d     = ST_CLEAR;
      end
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      col_q       <= 8'd0;
      row_q       <= 8'd0;
      pix_data_q  <= '0;
      pix_col_q   <= 8'd0;
      pix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef OBJ_SCANOUT_MOSAIC_EN
      mos_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pix_data_q  <= pix_data_d;
      pix_col_q   <= pix_col_d;
      pix_valid_q <= pix_valid_d;
      overrun_q   <= overrun_d;
`ifdef OBJ_SCANOUT_MOSAIC_EN
      mos_q       <= mos_d;
`endif
    end
  end

`ifdef OBJ_SCANOUT_MOSAIC_EN
  logic [7:0] rcol_map;
  obj_mosaic_col u_mosaic (
    .col_i     (col_q),
    .size_m1_i (mos_q),
    .base_o    (rcol_map)
  );
  assign bus.rcol = rcol_map;
`else
  assign bus.rcol = col_q;
`endif

  assign bus.row_q     = row_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_col   = pix_col_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.buf_clear = (state_q == ST_CLEAR);
  assign bus.line_done = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_obj_row_scanout.sv
// Directed bench for obj_row_scanout: timing, backpressure, overrun, reset abort,
// DRAIN hold and (with OBJ_SCANOUT_MOSAIC_EN) mosaic addressing.
module tb_obj_row_scanout;
  import obj_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   mos = 0;

  obj_row_scanout_if bus ();

  obj_row_scanout #(.NCOLS(OBJ_NCOLS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] model(input logic [7:0] r, input logic [7:0] c);
    return {r[3:0], c ^ 8'h5A, c};
  endfunction

  function automatic logic [7:0] src_col(input int c);
    return 8'(c - (c % (mos + 1)));
  endfunction

  // Row buffer model: read data is a fixed function of (row half, column).
  always_comb bus.rdata = model(bus.row_q, bus.rcol);

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: ready 1,0,1,0..., 2: stall 10 cycles on the last column
  task automatic scan_line(input logic [7:0] r, input int mode, input int ovr_at);
    int got = 0;
    int cyc = 0;
    int hold = 0;
    int clr_seen = 0;
    bit done = 0;
    bit rdy;
    bit stall_prev = 0;
    logic [7:0]  pc_prev = '0;
    logic [19:0] pd_prev = '0;
    logic [7:0]  rc_prev = '0;
    bus.pix_ready  = 1'b1;
    bus.row        = r;
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    bus.row        = 8'hEE;
    while (!done && cyc < 3000) begin
      bus.line_start = (cyc == ovr_at);
      bus.row        = r + 8'd4;
      case (mode)
        1:       rdy = (cyc % 2 == 0);
        2: begin
          rdy = 1'b1;
          if (bus.pix_valid && bus.pix_col == 8'd239 && hold < 10) begin
            rdy = 1'b0;
            hold++;
          end
        end
        default: rdy = 1'b1;
      endcase
      bus.pix_ready = rdy;
      if (stall_prev) begin
        chk("hold_col", bus.pix_col, pc_prev);
        chk("hold_data", bus.pix_data, pd_prev);
        chk("hold_valid", bus.pix_valid, 1);
        chk("hold_rcol", bus.rcol, rc_prev);
      end
      if (bus.pix_valid && rdy) begin
        chk("pix_col", bus.pix_col, got);
        chk("pix_data", bus.pix_data, model(r, src_col(got)));
        got++;
      end
      if (bus.buf_clear) begin
        clr_seen++;
        chk("clear_after_last", got, 240);
      end
      if (bus.line_done) begin
        done = 1;
        chk("clear_once", clr_seen, 1);
      end
      if (bus.busy) chk("row_q_stable", bus.row_q, r);
      stall_prev = bus.pix_valid && !rdy;
      pc_prev    = bus.pix_col;
      pd_prev    = bus.pix_data;
      rc_prev    = bus.rcol;
      tick;
      if (cyc == ovr_at) chk("overrun_set", bus.overrun, 1);
      cyc++;
    end
    bus.line_start = 1'b0;
    bus.pix_ready  = 1'b1;
    chk("line_done_seen", done, 1);
    chk("pixel_count", got, 240);
    if (mode == 2) chk("drain_hold", hold, 10);
    tick;
    chk("idle_after", bus.busy, 0);
  endtask

  initial begin
    int k;
    bus.line_start = 1'b0;
    bus.row        = 8'd0;
    bus.pix_ready  = 1'b1;
`ifdef OBJ_SCANOUT_MOSAIC_EN
    bus.mosaic_h   = 4'd0;
`endif
    repeat (2) tick;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rcol", bus.rcol, 0);
    chk("rst_row_q", bus.row_q, 0);
    chk("rst_pix_data", bus.pix_data, 0);
    chk("rst_pix_col", bus.pix_col, 0);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_buf_clear", bus.buf_clear, 0);
    chk("rst_line_done", bus.line_done, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset = 1'b1;
    tick;

    // Exact timing with no backpressure, row 5.
    bus.row        = 8'd5;
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    chk("c1_valid", bus.pix_valid, 0);
    chk("c1_rcol", bus.rcol, 0);
    chk("c1_row_q", bus.row_q, 5);
    tick;
    for (int c = 0; c < 240; c++) begin
      chk("t1_valid", bus.pix_valid, 1);
      chk("t1_col", bus.pix_col, c);
      chk("t1_data", bus.pix_data, model(8'd5, 8'(c)));
      chk("t1_no_clear", bus.buf_clear, 0);
      tick;
    end
    chk("c242_clear", bus.buf_clear, 1);
    chk("c242_valid", bus.pix_valid, 0);
    chk("c242_done", bus.line_done, 0);
    tick;
    chk("c243_done", bus.line_done, 1);
    chk("c243_clear", bus.buf_clear, 0);
    chk("c243_row_q", bus.row_q, 5);
    tick;
    chk("c244_idle", bus.busy, 0);
    chk("c244_done", bus.line_done, 0);
    chk("no_overrun", bus.overrun, 0);

    scan_line(8'd3, 1, -1);
    scan_line(8'd11, 2, -1);
    scan_line(8'd6, 0, 49);
    chk("overrun_sticky", bus.overrun, 1);

`ifdef OBJ_SCANOUT_MOSAIC_EN
    mos          = 3;
    bus.mosaic_h = 4'd3;
    scan_line(8'd2, 0, -1);
    bus.row        = 8'd9;
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    bus.mosaic_h   = 4'd0;
    for (int i = 0; i < 12; i++) begin
      chk("mos_rcol", bus.rcol, i - (i % 4));
      tick;
    end
    k = 0;
    while (!bus.line_done && k < 400) begin
      tick;
      k++;
    end
    chk("mos_line_done", bus.line_done, 1);
    tick;
    mos = 0;
`endif

    // Reset at cycle 100 of a scan aborts the line.
    bus.row        = 8'd7;
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    repeat (99) tick;
    chk("pre_rst_busy", bus.busy, 1);
    reset = 1'b0;
    tick;
    chk("ab_busy", bus.busy, 0);
    chk("ab_rcol", bus.rcol, 0);
    chk("ab_row_q", bus.row_q, 0);
    chk("ab_pix_data", bus.pix_data, 0);
    chk("ab_pix_col", bus.pix_col, 0);
    chk("ab_pix_valid", bus.pix_valid, 0);
    chk("ab_buf_clear", bus.buf_clear, 0);
    chk("ab_line_done", bus.line_done, 0);
    chk("ab_overrun", bus.overrun, 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("post_rst_clear", bus.buf_clear, 0);
      chk("post_rst_done", bus.line_done, 0);
      chk("post_rst_busy", bus.busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
